packet_source: RTL and testbench

- Traffic injector for one network node. Generates packet_t packets at a programmable rate to pseudo-random destinations.
- Holds generated packets in a small local queue and drives them into the local input port of the attached router.
- Uses the router's val/enable link handshake as the transmitting end: it drives data plus val, and obeys the router FIFO's not-full enable.
- Provides sent/dropped statistics for the simulation framework.

---
 rtl/packet_source.sv | 195 +++++++++++++++++++
 tb/tb_packet_source.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_source.sv
// Traffic injector for one network node: rate-limited packet generation
// into a small queue, driven onto the router's local val/enable input link.
package noc_pkg;
  typedef struct packed {
    logic [7:0]  hops;
    logic [7:0]  source;
    logic [7:0]  dest;
    logic [31:0] data;
  } packet_t;
endpackage

module packet_source
  import noc_pkg::*;
#(
  parameter int unsigned SOURCE_ID   = 0,
  parameter int unsigned NODES       = 16,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        i_enable,
  input  logic [7:0]  i_rate,
  input  logic        i_en,
  output packet_t     o_data,
  output logic        o_data_val,
  output logic        o_busy,
  output logic [31:0] o_sent_count,
  output logic [31:0] o_dropped_count
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [7:0] SRC = 8'(SOURCE_ID);
  localparam logic [7:0] ALT = 8'((SOURCE_ID + 1) % NODES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [31:0]   seq_q, seq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  packet_t       out_q, out_d;
  logic          val_q, val_d;
  logic [31:0]   sent_q, sent_d;
  logic [31:0]   drop_q, drop_d;
  packet_t       mem_q [QUEUE_DEPTH];

  logic          gen;
  logic          xfer;
  logic          can_load;
  logic          pop;
  logic          bypass;
  logic          push;
  logic          drop;
  logic          fb;
  logic [7:0]    dest_raw;
  logic [7:0]    dest_sel;
  logic [CW-1:0] cnt_rd;
  packet_t       gen_pkt;

  assign fb = lfsr_q[0] ^ lfsr_q[2]
            ^ lfsr_q[3] ^ lfsr_q[5];

  assign dest_raw =
    8'({24'd0, lfsr_q[15:8]} % NODES);

  assign dest_sel =
    (dest_raw == SRC) ? ALT : dest_raw;

  always_comb begin
    gen_pkt        = '0;
    gen_pkt.source = SRC;
    gen_pkt.dest   = dest_sel;
    gen_pkt.data   = seq_q;
  end

  // Output register has priority over the queue; the queue only
  // absorbs what the register cannot take this cycle.
  always_comb begin
    gen = (state_q == RUN) && i_enable
       && (lfsr_q[7:0] < i_rate);
    xfer     = val_q && i_en;
    can_load = !val_q || xfer;
    pop      = can_load && (cnt_q != '0);
    bypass   = can_load && (cnt_q == '0) && gen;
    cnt_rd   = cnt_q - CW'(pop);
    push     = gen && !bypass && (cnt_rd < FULL);
    drop     = gen && !bypass && !push;
  end

  always_comb begin
    out_d = out_q;
    val_d = val_q;
    if (pop) begin
      out_d = mem_q[rd_ptr_q];
      val_d = 1'b1;
    end else if (bypass) begin
      out_d = gen_pkt;
      val_d = 1'b1;
    end else if (can_load) begin
      val_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    seq_d    = seq_q + 32'(push || bypass);
    lfsr_d   = lfsr_q;
    if (state_q == RUN) begin
      lfsr_d = {fb, lfsr_q[15:1]};
    end
  end

  always_comb begin
    sent_d = sent_q;
    drop_d = drop_q;
    if (xfer && (sent_q != '1)) begin
      sent_d = sent_q + 32'd1;
    end
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_enable) state_d = RUN;
      end
      RUN: begin
        if (!i_enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (i_enable) begin
          state_d = RUN;
        end else if ((cnt_q == '0) && can_load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      seq_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      val_q    <= 1'b0;
      sent_q   <= '0;
      drop_q   <= '0;
    end else if (ce) begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      seq_q    <= seq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      val_q    <= val_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ce && push) begin
      mem_q[wr_ptr_q] <= gen_pkt;
    end
  end

  assign o_data          = out_q;
  assign o_data_val      = val_q;
  assign o_busy          = (state_q != IDLE);
  assign o_sent_count    = sent_q;
  assign o_dropped_count = drop_q;

endmodule

// File: tb/tb_packet_source.sv
// Scoreboard bench for packet_source: occupancy model predicts packets,
// a monitor pops and compares each transfer on the router link.
module tb_packet_source;
  import noc_pkg::*;

  localparam int SRC   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        i_enable = 1'b0;
  logic [7:0]  i_rate = 8'd0;
  logic        i_en = 1'b0;
  packet_t     o_data;
  logic        o_data_val;
  logic        o_busy;
  logic [31:0] o_sent_count;
  logic [31:0] o_dropped_count;

  int vectors = 0;
  int miscompares = 0;

  packet_t exp_q[$];
  int      mon_sent = 0;

  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_e;
  mstate_e     m_state = M_IDLE;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [31:0] m_seq = 0;
  int          m_occ = 0;
  logic [31:0] m_drop = 0;

  packet_source #(
    .SOURCE_ID(SRC),
    .NODES(16),
    .QUEUE_DEPTH(DEPTH),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ce(ce),
    .i_enable(i_enable),
    .i_rate(i_rate),
    .i_en(i_en),
    .o_data(o_data),
    .o_data_val(o_data_val),
    .o_busy(o_busy),
    .o_sent_count(o_sent_count),
    .o_dropped_count(o_dropped_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: inputs are stable across the negedge, so it predicts the
  // effect of the coming posedge from the node's occupancy.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_state = M_IDLE;
      m_lfsr  = 16'hACE1;
      m_seq   = 0;
      m_occ   = 0;
      m_drop  = 0;
      exp_q.delete();
    end else begin
      chk("val", {63'd0, o_data_val},
          {63'd0, m_occ != 0});
      chk("busy", {63'd0, o_busy},
          {63'd0, m_state != M_IDLE});
      chk("dropped", {32'd0, o_dropped_count},
          {32'd0, m_drop});
      if (ce) begin
        int xf;
        logic g;
        xf = (m_occ != 0 && i_en) ? 1 : 0;
        g = (m_state == M_RUN) && i_enable
            && (m_lfsr[7:0] < i_rate);
        if (g) begin
          if (m_occ - xf < DEPTH + 1) begin
            packet_t p;
            int d;
            p = '0;
            d = int'(m_lfsr[15:8]) % 16;
            if (d == SRC) d = SRC + 1;
            p.source = 8'(SRC);
            p.dest   = 8'(d);
            p.data   = m_seq;
            exp_q.push_back(p);
            m_seq = m_seq + 1;
            m_occ = m_occ - xf + 1;
          end else begin
            m_drop = m_drop + 1;
            m_occ = m_occ - xf;
          end
        end else begin
          m_occ = m_occ - xf;
        end
        case (m_state)
          M_IDLE:
            if (i_enable) m_state = M_RUN;
          M_RUN: begin
            if (!i_enable) m_state = M_DRAIN;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2]
                      ^ m_lfsr[3] ^ m_lfsr[5],
                      m_lfsr[15:1]};
          end
          default:
            if (i_enable) m_state = M_RUN;
            else if (m_occ == 0) m_state = M_IDLE;
        endcase
      end
    end
  end

  // Monitor: a transfer is due at the next posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_sent = 0;
    end else if (ce && o_data_val && i_en) begin
      mon_sent++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pkt: unexpected %0h, none queued",
                 o_data);
      end else begin
        chk("pkt", {8'd0, o_data},
            {8'd0, exp_q.pop_front()});
      end
      chk("dest_not_self", {63'd0, o_data.dest == 8'(SRC)},
          64'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (o_busy && k < 300) begin
      cyc(1);
      k++;
    end
    chk(name, {63'd0, o_busy}, 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(3);
    chk("rst_val", {63'd0, o_data_val}, 64'd0);
    chk("rst_data", {8'd0, o_data}, 64'd0);
    chk("rst_sent", {32'd0, o_sent_count}, 64'd0);
    chk("rst_drop", {32'd0, o_dropped_count}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    packet_t snap;
    cyc(1);
    do_reset();
    cyc(20);
    chk("idle_val", {63'd0, o_data_val}, 64'd0);

    i_rate = 8'd255;
    i_en = 1'b1;
    i_enable = 1'b1;
    cyc(1000);
    chk("full_rate_drop", {32'd0, o_dropped_count}, 64'd0);
    chk("full_rate_sent", {32'd0, o_sent_count},
        {32'd0, 32'(mon_sent)});
    i_enable = 1'b0;
    wait_idle("drain1_idle");
    chk("drain1_empty", 64'(exp_q.size()), 64'd0);

    do_reset();
    i_en = 1'b0;
    i_enable = 1'b1;
    cyc(30);
    chk("held_val", {63'd0, o_data_val}, 64'd1);
    chk("held_data0", {32'd0, o_data.data}, 64'd0);
    chk("held_count", 64'(exp_q.size()), 64'd5);
    snap = o_data;
    cyc(10);
    chk("held_stable", {8'd0, o_data}, {8'd0, snap});
    chk("drops_grow", {63'd0, o_dropped_count > 32'd30},
        64'd1);
    i_enable = 1'b0;
    cyc(5);
    chk("drain_hold", {63'd0, o_busy}, 64'd1);
    i_en = 1'b1;
    cyc(2);
    i_enable = 1'b1;
    cyc(3);
    i_enable = 1'b0;
    wait_idle("drain2_idle");
    chk("drain2_empty", 64'(exp_q.size()), 64'd0);
    chk("drain2_sent", {32'd0, o_sent_count},
        {32'd0, 32'(mon_sent)});

    i_rate = 8'd0;
    i_enable = 1'b1;
    cyc(100);
    chk("rate0_busy", {63'd0, o_busy}, 64'd1);
    chk("rate0_val", {63'd0, o_data_val}, 64'd0);
    i_rate = 8'd128;
    for (int i = 0; i < 200; i++) begin
      i_en = (i % 5) != 0 && (i % 7) != 3;
      cyc(1);
    end
    i_en = 1'b1;
    i_rate = 8'd200;
    for (int i = 0; i < 100; i++) begin
      ce = (i % 2) == 0;
      cyc(1);
    end
    ce = 1'b1;
    chk("ce_sent", {32'd0, o_sent_count},
        {32'd0, 32'(mon_sent)});
    for (int k = 0; k < 50 && !o_data_val; k++) cyc(1);
    chk("burst_val", {63'd0, o_data_val}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_val", {63'd0, o_data_val}, 64'd0);
    chk("async_sent", {32'd0, o_sent_count}, 64'd0);
    chk("async_drop", {32'd0, o_dropped_count}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
